// File: rtl/pixel_gamma_pipe_pkg.sv
// pixel_gamma_pipe_pkg: RGB565 field offsets, FSM states and the 64x6 gamma/identity tables.
package pixel_gamma_pipe_pkg;
    localparam int LUT_DEPTH_BITS = 6;
    localparam int NUM_LOOKUPS = 6;
    localparam int R_LSB = 11;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam logic [5:0] GAMMA_LUT [64] = '{
        6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd1,
        6'd1,  6'd1,  6'd1,  6'd1,  6'd2,  6'd2,  6'd2,  6'd3,
        6'd3,  6'd4,  6'd4,  6'd5,  6'd5,  6'd6,  6'd6,  6'd7,
        6'd8,  6'd8,  6'd9,  6'd10, 6'd11, 6'd11, 6'd12, 6'd13,
        6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd20, 6'd21, 6'd22,
        6'd23, 6'd24, 6'd26, 6'd27, 6'd29, 6'd30, 6'd32, 6'd33,
        6'd35, 6'd36, 6'd38, 6'd40, 6'd41, 6'd43, 6'd45, 6'd47,
        6'd49, 6'd51, 6'd53, 6'd55, 6'd57, 6'd59, 6'd61, 6'd63
    };
    function automatic logic [63:0][5:0] build_identity_lut();
        logic [63:0][5:0] t;
        for (int i = 0; i < 64; i++) t[i] = 6'(i);
        return t;
    endfunction
endpackage

// File: rtl/pixel_gamma_pipe_rom.sv
// gamma_lut_rom: 64x6 synchronous-read ROM, gamma table when PIXEL_GAMMA_LUT_EN is defined, identity otherwise.
module gamma_lut_rom
    import pixel_gamma_pipe_pkg::*;
(
    input  logic                      clk_in,
    input  logic [LUT_DEPTH_BITS-1:0] addr,
    output logic [5:0]                data
);
`ifdef PIXEL_GAMMA_LUT_EN
    always_ff @(posedge clk_in) data <= GAMMA_LUT[addr];
`else
    localparam logic [63:0][5:0] ID_LUT = build_identity_lut();
    always_ff @(posedge clk_in) data <= ID_LUT[addr];
`endif
endmodule

// File: rtl/pixel_gamma_pipe.sv
// pixel_gamma_pipe: gamma-corrects an RGB565 top/bottom pair through one shared LUT (PIXEL_GAMMA_LUT_EN selects gamma vs identity).
module pixel_gamma_pipe
    import pixel_gamma_pipe_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset,
    input  logic        pixel_load_start,
    input  logic [15:0] rgb565_top_in,
    input  logic [15:0] rgb565_bottom_in,
    output logic [15:0] rgb565_top_out,
    output logic [15:0] rgb565_bottom_out,
    output logic        valid,
    output logic        busy,
    output logic        overrun
);
    state_t state, state_nxt;
    logic [2:0] idx, rd_idx;
    logic rd_vld;
    logic [15:0] top_q, bot_q, pix;
    logic [31:0] stage, stage_nxt;
    logic [1:0] sub;
    logic [LUT_DEPTH_BITS-1:0] addr;
    logic [5:0] lut_q;

    // channel order: top R,G,B then bottom R,G,B; 5-bit channels replicate their MSB
    assign pix  = idx >= 3'd3 ? bot_q : top_q;
    assign sub  = idx >= 3'd3 ? 2'(idx - 3'd3) : idx[1:0];
    assign addr = sub == 2'd1 ? pix[G_LSB +: 6] :
                  sub == 2'd0 ? {pix[R_LSB +: 5], pix[R_LSB+4]} : {pix[B_LSB +: 5], pix[B_LSB+4]};

    gamma_lut_rom u_rom (.clk_in(clk_in), .addr(addr), .data(lut_q));

    // the ROM output belongs to the channel issued one cycle earlier (rd_idx)
    always_comb begin
        stage_nxt = stage;
        if (rd_vld)
            case (rd_idx)
                3'd0:    stage_nxt[16+R_LSB +: 5] = lut_q[5:1];
                3'd1:    stage_nxt[16+G_LSB +: 6] = lut_q;
                3'd2:    stage_nxt[16+B_LSB +: 5] = lut_q[5:1];
                3'd3:    stage_nxt[R_LSB +: 5]    = lut_q[5:1];
                3'd4:    stage_nxt[G_LSB +: 6]    = lut_q;
                default: stage_nxt[B_LSB +: 5]    = lut_q[5:1];
            endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pixel_load_start ? ISSUE : IDLE;
            ISSUE:   state_nxt = idx == 3'(NUM_LOOKUPS-1) ? DRAIN : ISSUE;
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign valid = state == DONE;
    assign busy  = state == ISSUE || state == DRAIN;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state             <= IDLE;
            idx               <= '0;
            rd_idx            <= '0;
            rd_vld            <= 1'b0;
            top_q             <= '0;
            bot_q             <= '0;
            stage             <= '0;
            rgb565_top_out    <= '0;
            rgb565_bottom_out <= '0;
            overrun           <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= state == ISSUE ? idx + 3'd1 : 3'd0;
            rd_idx <= idx;
            rd_vld <= state == ISSUE;
            stage  <= stage_nxt;
            if (state == IDLE && pixel_load_start) begin
                top_q <= rgb565_top_in;
                bot_q <= rgb565_bottom_in;
            end
            if (state != IDLE && pixel_load_start) overrun <= 1'b1;
            // the last channel is merged straight from the ROM so both halves land together in DONE
            if (state == DRAIN) {rgb565_top_out, rgb565_bottom_out} <= stage_nxt;
        end
    end
endmodule
